// File: rtl/data_memory_rv32.sv
// Byte-addressable RV32 data memory with a fixed access latency, a busywait
// stall handshake and combinational misalignment/illegal-access detection.
module data_memory_rv32 #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  busywait,
    output logic                  fault
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            func3_q;
    logic [31:0]           wdata_q;
    logic                  is_write_q;
    logic [31:0]           rdata_q;
    logic [7:0]            mem_q [DEPTH];

    logic                  valid_c;
    logic                  illegal_c;
    logic                  accept_c;
    logic                  access_c;
    logic [ADDR_WIDTH-1:0] a0_c, a1_c, a2_c, a3_c;
    logic [7:0]            b0_c, b1_c, b2_c, b3_c;
    logic [3:0]            be_c;
    logic [31:0]           load_c;

    assign valid_c  = read ^ write;
    assign accept_c = valid_c && !illegal_c;
    assign access_c = (state_q == S_BUSY) && (cnt_q == '0);
    assign readdata = rdata_q;

    // Alignment and encoding legality of the live request
    always_comb begin
        illegal_c = 1'b1;
        case (func3)
            F_B:     illegal_c = 1'b0;
            F_H:     illegal_c = address[0];
            F_W:     illegal_c = |address[1:0];
            F_BU:    illegal_c = write;
            F_HU:    illegal_c = write | address[0];
            default: illegal_c = 1'b1;
        endcase
    end

    // Stall and fault are combinational so the pipeline reacts in the request cycle
    always_comb begin
        busywait = 1'b0;
        fault    = 1'b0;
        if (reset) begin
            case (state_q)
                S_IDLE: begin
                    busywait = accept_c;
                    fault    = valid_c && illegal_c;
                end
                S_BUSY:  busywait = 1'b1;
                default: busywait = 1'b0;
            endcase
        end
    end

    always_comb begin
        a0_c = addr_q;
        a1_c = addr_q + ADDR_WIDTH'(1);
        a2_c = addr_q + ADDR_WIDTH'(2);
        a3_c = addr_q + ADDR_WIDTH'(3);
        b0_c = mem_q[a0_c];
        b1_c = mem_q[a1_c];
        b2_c = mem_q[a2_c];
        b3_c = mem_q[a3_c];
    end

    // Little-endian load extraction with sign/zero extension
    always_comb begin
        load_c = '0;
        case (func3_q)
            F_B:     load_c = {{24{b0_c[7]}}, b0_c};
            F_BU:    load_c = {24'h000000, b0_c};
            F_H:     load_c = {{16{b1_c[7]}}, b1_c, b0_c};
            F_HU:    load_c = {16'h0000, b1_c, b0_c};
            F_W:     load_c = {b3_c, b2_c, b1_c, b0_c};
            default: load_c = '0;
        endcase
    end

    always_comb begin
        case (func3_q[1:0])
            2'b00:   be_c = 4'b0001;
            2'b01:   be_c = 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            func3_q    <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        addr_q     <= address;
                        func3_q    <= func3;
                        wdata_q    <= writedata;
                        is_write_q <= write;
                        cnt_q      <= CNT_W'(LATENCY - 1);
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        if (!is_write_q) begin
                            rdata_q <= load_c;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                // The stalled request is still asserted here, so it is not re-accepted
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage: cleared on reset, written only on the access edge of a store
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: 8'h00};
        end else if (access_c && is_write_q) begin
            if (be_c[0]) mem_q[a0_c] <= wdata_q[7:0];
            if (be_c[1]) mem_q[a1_c] <= wdata_q[15:8];
            if (be_c[2]) mem_q[a2_c] <= wdata_q[23:16];
            if (be_c[3]) mem_q[a3_c] <= wdata_q[31:24];
        end
    end

endmodule
